run_ctrl: RTL
=============

Name: run_ctrl

Overview:
- Program-execution sequencer for the single-cycle processor in top_level.
- On a start request (li), it loads the start PC and enables execution until the decoder flags a halt instruction. It then drains in-flight writes and raises done for the bench.
- A watchdog ends runaway programs.
- Sits between the testbench-facing pins (li, done) and the PC/register-file/data-memory enables.

Parameters:
- PC_W, 10, program counter width
- START_PC, 0, PC value loaded at the start of every run
- CNT_W, 16, width of the cycle counter
- MAX_CYCLES, 4096, watchdog limit on RUN cycles (must be ≤ 2^CNT_W-1)
- DRAIN_CYC, 2, cycles spent in DRAIN after halt or timeout (0 allowed)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- li  in  1  start request, level sampled on clk
- halt_in  in  1  decoder: current instruction is HALT (combinational from the core)
- pc_load  out  1  PC loads pc_target this cycle
- pc_target  out  PC_W  value to load into PC
- run_en  out  1  PC advance / architectural write enable
- busy  out  1  high in LOAD, RUN, DRAIN
- done  out  1  run finished; held until the next run starts
- timeout  out  1  last run ended by the watchdog (sticky)
- cycle_cnt  out  CNT_W  RUN cycles of the current/last run

Behaviour:
- Reset (async, any state): state=IDLE; cycle_cnt=0, drain counter=0, timeout=0, done=0, pc_load=0, run_en=0, busy=0, pc_target=START_PC.
- States: IDLE, LOAD, RUN, DRAIN, FIN; encoding is defined in the package.
- IDLE: if li=1 at clk, go to LOAD.
- LOAD (exactly 1 cycle):
  - pc_load=1, pc_target=START_PC, run_en=0.
  - cycle_cnt and timeout cleared at the clock edge leaving LOAD; next state RUN.
- RUN:
  - run_en = ~halt_in (combinational), so the HALT instruction never advances the PC or writes.
  - cycle_cnt increments every RUN cycle, including the halt cycle; saturates at 2^CNT_W-1.
  - If halt_in=1: go to DRAIN.
  - Else if cycle_cnt == MAX_CYCLES-1: go to DRAIN and set timeout=1.
  - Halt and the limit in the same cycle: halt wins, timeout stays 0.
- DRAIN:
  - run_en=0; counts DRAIN_CYC cycles, then goes to FIN.
  - DRAIN_CYC=0: skip DRAIN, going RUN→FIN directly.
- FIN:
  - done=1, busy=0.
  - li=1 re-arms: go to LOAD; done drops on that edge.
- li is ignored in LOAD, RUN and DRAIN.
- halt_in is ignored outside RUN.
- Outputs other than run_en are registered or decoded from state only; no combinational path from li to any output.
- Reset mid-run: all outputs return to reset values within the same cycle (async); the next run requires li.

Optional Feature:
- Macro RUN_CTRL_STEP_EN.
- Defined:
  - Adds ports step_mode (in 1) and step (in 1).
  - When step_mode=1 in RUN, run_en is high only in the cycle after a rising edge of step.
  - One instruction per pulse; cycle_cnt counts only enabled cycles.
  - A halt still terminates the run immediately.
  - step_mode=0 behaves as free-running.
- Not defined: the ports are absent and RUN is always free-running.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum typedef (run_state_t)
  - default constants for START_PC, MAX_CYCLES, DRAIN_CYC
- Sub-module sat_counter (parameter W; ports clr, inc, q) implements cycle_cnt and is reused for the drain counter.

Test Plan:
- Reset then li pulse at cycle 3; halt_in at the 5th RUN cycle → pc_load=1 with pc_target=0 for 1 cycle, run_en high 4 cycles then low on the halt cycle, cycle_cnt=5, done high 2 cycles after leaving RUN, timeout=0.
- MAX_CYCLES=8, halt never asserted → exactly 8 RUN cycles, timeout=1, done=1, cycle_cnt=8.
- MAX_CYCLES=8, halt asserted on the 8th RUN cycle → timeout=0, cycle_cnt=8.
- Assert reset during RUN with cycle_cnt=3 → all outputs are 0 immediately; after release, state stays IDLE with done=0 until li.
- From FIN, pulse li again → done drops, pc_load pulses, cycle_cnt and timeout restart from 0. li held high during RUN → no effect.
- Build with RUN_CTRL_STEP_EN, step_mode=1, three step pulses 4 cycles apart → run_en is high for exactly 3 single cycles and cycle_cnt=3.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default constants for the
// program-execution sequencer (run_ctrl) and its helpers.
package run_ctrl_pkg;

  // Sequencer states; IDLE is the reset state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } run_state_t;

  // Defaults used by run_ctrl when the parent does not override them.
  localparam int DEF_START_PC   = 0;
  localparam int DEF_MAX_CYCLES = 4096;
  localparam int DEF_DRAIN_CYC  = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Used for the run cycle count and for the drain cycle count.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear has priority over increment; the count never wraps past all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: starts a program on li, lets the core run until it decodes HALT
// (or the watchdog fires), drains in-flight writes, then raises done.
// Optional single-step support is compiled in with `define RUN_CTRL_STEP_EN,
// which adds the step_mode and step ports.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_PC   = DEF_START_PC,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             li,
  input  logic             halt_in,
`ifdef RUN_CTRL_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
  localparam int DW         = (DRAIN_LAST < 1) ? 1 : $clog2(DRAIN_LAST + 1);
  localparam run_state_t END_STATE = (DRAIN_CYC == 0) ? FIN : DRAIN;

  run_state_t       state;
  run_state_t       state_n;
  logic [DW-1:0]    drain_cnt;
  logic             en_slot;
  logic             at_limit;
  logic             drain_last;

`ifdef RUN_CTRL_STEP_EN
  logic step_prev;
  logic step_fire;

  // Turn each rising edge of step into a one-cycle execute slot on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev <= 1'b0;
      step_fire <= 1'b0;
    end else begin
      step_prev <= step;
      step_fire <= step & ~step_prev;
    end
  end

  assign en_slot = ~step_mode | step_fire;
`else
  assign en_slot = 1'b1;
`endif

  assign at_limit   = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign drain_last = (drain_cnt == DW'(DRAIN_LAST));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and the only combinational output, run_en (HALT never advances).
  always_comb begin
    state_n = state;
    run_en  = 1'b0;
    case (state)
      IDLE:  if (li) state_n = LOAD;
      LOAD:  state_n = RUN;
      RUN: begin
        run_en = ~halt_in & en_slot;
        if (halt_in) begin
          state_n = END_STATE;
        end else if (en_slot && at_limit) begin
          state_n = END_STATE;
        end
      end
      DRAIN: if (drain_last) state_n = FIN;
      FIN:   if (li) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // Watchdog flag: cleared when a run is launched, set only when the limit ends RUN without a halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (state == LOAD) begin
      timeout <= 1'b0;
    end else if ((state == RUN) && !halt_in && en_slot && at_limit) begin
      timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .inc   ((state == RUN) && en_slot),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(DW)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state != DRAIN),
    .inc   (state == DRAIN),
    .q     (drain_cnt)
  );

  assign pc_load   = (state == LOAD);
  assign pc_target = PC_W'(START_PC);
  assign busy      = (state == LOAD) || (state == RUN) || (state == DRAIN);
  assign done      = (state == FIN);

endmodule
